// File: rtl/div_if.sv
// div_if: divide request/response bundle between execute stage (master) and div_seq (slave)
interface div_if #(parameter int WIDTH = 32);
  logic start;
  logic signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic annul;
  logic stall_div;
  logic ready;
  logic [2*WIDTH-1:0] result;
  modport master(output start, signed_div, opa, opb, annul, input stall_div, ready, result);
  modport slave(input start, signed_div, opa, opb, annul, output stall_div, ready, result);
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring DIV/DIVU; ports clk, rst, d (div_if.slave: start/signed_div/opa/opb/annul in, stall_div/ready/result={rem,quot} out)
module div_seq #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  div_if.slave d
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DIVZERO, DIVON, DIVEND} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quot, dvs, abs_a, abs_b, rem_n, quot_n;
  logic [WIDTH:0] w, diff;
  logic sdiv, sa, sb, rdy, accept, last;
  logic [2*WIDTH-1:0] res;
  assign accept = state == IDLE && d.start && !d.annul;
  assign last = cnt == CW'(WIDTH - 1);
  assign abs_a = (d.signed_div && d.opa[WIDTH-1]) ? -d.opa : d.opa;
  assign abs_b = (d.signed_div && d.opb[WIDTH-1]) ? -d.opb : d.opb;
  // one restoring step; the borrow out of diff decides whether to subtract
  assign w = {rem, quot[WIDTH-1]};
  assign diff = w - {1'b0, dvs};
  assign rem_n = diff[WIDTH] ? w[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_n = {quot[WIDTH-2:0], ~diff[WIDTH]};
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = d.annul ? IDLE :
              state == IDLE ? (d.start ? (d.opb == '0 ? DIVZERO : DIVON) : IDLE) :
              state == DIVZERO ? DIVEND :
              state == DIVON ? (last ? DIVEND : DIVON) : IDLE;
  end
  always_comb begin
    d.stall_div = d.start & ~rdy & ~d.annul;
    d.ready = rdy;
    d.result = res;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {sdiv, sa, sb, rdy} <= '0;
      {rem, quot, dvs, cnt, res} <= '0;
    end else begin
      rdy <= state_n == DIVEND;
      if (accept) begin
        sdiv <= d.signed_div;
        sa <= d.opa[WIDTH-1];
        sb <= d.opb[WIDTH-1];
        dvs <= abs_b;
        rem <= '0;
        quot <= abs_a;
        cnt <= '0;
      end else if (state == DIVON) begin
        rem <= rem_n;
        quot <= quot_n;
        cnt <= d.annul ? '0 : cnt + 1'b1;
      end else if (d.annul) cnt <= '0;
      // quotient negated on sign mismatch, remainder follows the dividend sign
      if (state == DIVON && last && !d.annul)
        res <= {(sdiv & sa) ? -rem_n : rem_n, (sdiv & (sa ^ sb)) ? -quot_n : quot_n};
      else if (state == DIVZERO && !d.annul) res <= '0;
    end
  end
endmodule
